// File: rtl/controller_pkg.sv
// Shared opcode/ALUOp encodings and the control-field struct for the main controller.
package controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Datapath control fields produced by the decoder. branch_ne selects ~Zero for PCSrc.
  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    reg_dst:    1'b0,
    alu_op:     ALUOP_ADD,
    alu_src:    1'b0,
    branch:     1'b0,
    branch_ne:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0
  };

endpackage

// File: rtl/controller_main_decoder.sv
// Combinational opcode decoder: opcode -> control struct plus illegal-opcode flag.
module main_decoder
  import controller_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Decode opcode; unknown opcodes leave every control at zero so nothing is written.
  always_comb begin
    ctrl    = CTRL_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.reg_write = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/controller.sv
// Main control unit: decodes the opcode, resolves PCSrc from Zero, registers all outputs.
module controller
  import controller_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction,
  input  logic        Zero,
  output logic        RegDst,
  output logic [1:0]  ALUOp,
  output logic        ALUZero,
  output logic        ALUSrc,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        PCSrc,
  output logic        Debug
);

  ctrl_t ctrl;
  logic  illegal;
  logic  pc_src;

  main_decoder u_main_decoder (
    .opcode  (Instruction[31:26]),
    .ctrl    (ctrl),
    .illegal (illegal)
  );

  // Branch resolution: beq takes on Zero, bne on ~Zero; non-branches never take.
  always_comb begin
    pc_src = 1'b0;
    if (ctrl.branch) begin
      pc_src = ctrl.branch_ne ? ~Zero : Zero;
    end
  end

  // Output register; synchronous reset has priority over decode.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      RegDst   <= 1'b0;
      ALUOp    <= 2'b00;
      ALUZero  <= 1'b0;
      ALUSrc   <= 1'b0;
      Branch   <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      MemtoReg <= 1'b0;
      RegWrite <= 1'b0;
      PCSrc    <= 1'b0;
      Debug    <= 1'b0;
    end else begin
      RegDst   <= ctrl.reg_dst;
      ALUOp    <= ctrl.alu_op;
      ALUZero  <= Zero;
      ALUSrc   <= ctrl.alu_src;
      Branch   <= ctrl.branch;
      MemRead  <= ctrl.mem_read;
      MemWrite <= ctrl.mem_write;
      MemtoReg <= ctrl.mem_to_reg;
      RegWrite <= ctrl.reg_write;
      PCSrc    <= pc_src;
      Debug    <= illegal;
    end
  end

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: drive one instruction per cycle, compare registered outputs.
module tb_controller;

  logic        Clk;
  logic        Rst;
  logic [31:0] Instruction;
  logic        Zero;
  logic        RegDst;
  logic [1:0]  ALUOp;
  logic        ALUZero;
  logic        ALUSrc;
  logic        Branch;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic        PCSrc;
  logic        Debug;

  int checks;
  int failures;

  controller dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Instruction (Instruction),
    .Zero        (Zero),
    .RegDst      (RegDst),
    .ALUOp       (ALUOp),
    .ALUZero     (ALUZero),
    .ALUSrc      (ALUSrc),
    .Branch      (Branch),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .PCSrc       (PCSrc),
    .Debug       (Debug)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Bit order: RegDst, ALUOp[1:0], ALUZero, ALUSrc, Branch, MemRead, MemWrite, MemtoReg,
  // RegWrite, PCSrc, Debug.
  function automatic logic [11:0] mk(input logic reg_dst, input logic [1:0] alu_op,
                                     input logic alu_zero, input logic alu_src,
                                     input logic branch, input logic mem_read,
                                     input logic mem_write, input logic mem_to_reg,
                                     input logic reg_write, input logic pc_src,
                                     input logic debug);
    return {reg_dst, alu_op, alu_zero, alu_src, branch, mem_read, mem_write, mem_to_reg,
            reg_write, pc_src, debug};
  endfunction

  function automatic logic [11:0] observed();
    return {RegDst, ALUOp, ALUZero, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite,
            PCSrc, Debug};
  endfunction

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic [31:0] instr, input logic zero);
    Rst         = rst;
    Instruction = instr;
    Zero        = zero;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    step(1'b1, 32'h0000_0000, 1'b0);
    check("reset", mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    step(1'b0, 32'h0000_0020, 1'b0);
    check("rtype", mk(1, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    step(1'b0, 32'h0000_0020, 1'b1);
    check("rtype_zero1", mk(1, 2'b10, 1, 0, 0, 0, 0, 0, 1, 0, 0));

    step(1'b0, 32'h8C01_0000, 1'b0);
    check("lw", mk(0, 2'b00, 0, 1, 0, 1, 0, 1, 1, 0, 0));

    step(1'b0, 32'h8FFF_FFFF, 1'b1);
    check("lw_low_bits_zero1", mk(0, 2'b00, 1, 1, 0, 1, 0, 1, 1, 0, 0));

    step(1'b0, 32'hAC01_0000, 1'b0);
    check("sw", mk(0, 2'b00, 0, 1, 0, 0, 1, 0, 0, 0, 0));

    step(1'b0, 32'h1001_0000, 1'b1);
    check("beq_taken", mk(0, 2'b01, 1, 0, 1, 0, 0, 0, 0, 1, 0));

    // Inputs change between edges; registered outputs must hold.
    Instruction = 32'hAC01_0000;
    Zero        = 1'b0;
    #3;
    check("hold_between_edges", mk(0, 2'b01, 1, 0, 1, 0, 0, 0, 0, 1, 0));

    step(1'b0, 32'h1001_0000, 1'b0);
    check("beq_not_taken", mk(0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    step(1'b0, 32'h1401_0000, 1'b0);
    check("bne_taken", mk(0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 1, 0));

    step(1'b0, 32'h1401_0000, 1'b1);
    check("bne_not_taken", mk(0, 2'b01, 1, 0, 1, 0, 0, 0, 0, 0, 0));

    step(1'b0, 32'h2001_0005, 1'b0);
    check("addi", mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0, 0));

    step(1'b0, 32'hFFFF_FFFF, 1'b1);
    check("illegal_ff", mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1));

    step(1'b0, 32'h0400_0000, 1'b0);
    check("illegal_op01", mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    check("reset_clears_debug", mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    step(1'b0, 32'h8C01_0000, 1'b0);
    check("lw_after_reset", mk(0, 2'b00, 0, 1, 0, 1, 0, 1, 1, 0, 0));

    step(1'b1, 32'h1001_0000, 1'b1);
    check("reset_over_beq", mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    step(1'b0, 32'h1001_0000, 1'b1);
    check("beq_resume", mk(0, 2'b01, 1, 0, 1, 0, 0, 0, 0, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
